al422_write_ctrl: RTL
=====================

AL422_WRITE_CTRL -- requirements
Module: al422_write_ctrl

Interface
REQ-001 Parameter FRAME_BYTES, default 1024, bytes per frame written to the AL422B (range 2..65535).
REQ-002 Parameter WRST_CYCLES, default 2, cycles al422_wrst_n is held low before a frame (range 1..15).
REQ-003 in_clk  input  1  single clock; all logic on its rising edge.
REQ-004 in_rst  input  1  reset, synchronous, active-high.
REQ-005 frame_req  input  1  request to write one frame; sampled only in IDLE.
REQ-006 s_data  input  8  pixel byte (rgb1 in [2:0], rgb2 in [5:3], [7:6] pass-through).
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_last  input  1  marks the final byte of a frame; qualified by s_valid.
REQ-009 s_ready  output  1  byte accepted when s_valid and s_ready are both high.
REQ-010 al422_data  output  8  AL422B write data.
REQ-011 al422_we_n  output  1  AL422B write enable, active-low.
REQ-012 al422_wrst_n  output  1  AL422B write-pointer reset, active-low.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse when a complete frame has been written.
REQ-015 frame_cnt  output  8  completed-frame count, wraps 255 -> 0.
REQ-016 err  output  1  sticky frame-length error flag (see Configuration).

Function
REQ-017 The block SHALL implement exactly the states IDLE, WRST, WRITE and DONE.
REQ-018 IDLE: s_ready=0, we_n=1, wrst_n=1; on frame_req=1 the block SHALL go to WRST next cycle.
REQ-019 WRST: wrst_n=0 for exactly WRST_CYCLES cycles, s_ready=0; the byte counter SHALL clear; the block then goes to WRITE.
REQ-020 WRITE: s_ready=1; each accepted byte SHALL appear on al422_data with al422_we_n=0 exactly one cycle after acceptance (registered, 1-cycle latency).
REQ-021 al422_we_n SHALL be 1 in every cycle following a cycle with no accepted byte; gaps in s_valid produce gaps in writes.
REQ-022 The 16-bit byte counter SHALL increment per accepted byte; acceptance at count FRAME_BYTES-1 SHALL deassert s_ready in the next cycle and enter DONE.
REQ-023 DONE: lasts one cycle, carries the final al422_we_n=0 write, pulses frame_done=1, increments frame_cnt, then returns to IDLE.
REQ-024 frame_req in WRST, WRITE or DONE SHALL be ignored (not queued).
REQ-025 s_valid in IDLE, WRST or DONE SHALL NOT be accepted and SHALL NOT cause writes.
REQ-026 Back-to-back frames: frame_req held high SHALL re-enter WRST on the cycle after DONE->IDLE, giving a minimum of 1 IDLE cycle between frames.
REQ-027 al422_wrst_n and al422_we_n SHALL never both be low in the same cycle.

Reset
REQ-028 in_rst=1 SHALL, at the next edge, force IDLE, s_ready=0, al422_data=0, al422_we_n=1, al422_wrst_n=1, busy=0, frame_done=0, frame_cnt=0, err=0, counter=0.
REQ-029 Reset mid-WRITE SHALL abandon the partial frame without a frame_done pulse; the next frame SHALL begin with a full WRST phase.

Configuration
REQ-030 Macro AL422_WR_FRAME_CHECK_EN SHALL enable frame-length checking against s_last.
REQ-031 With it defined: accepted s_last at count < FRAME_BYTES-1 SHALL set err, write that byte, skip frame_done and frame_cnt increment, and return to IDLE via a one-cycle DONE state with frame_done=0.
REQ-032 With it defined: a final byte (count FRAME_BYTES-1) accepted without s_last SHALL set err but still complete the frame normally.
REQ-033 With it defined: err SHALL clear only on in_rst.
REQ-034 Without it: s_last SHALL be ignored, err SHALL be tied 0, and frame length SHALL be defined by the counter alone.

Verification
REQ-035 Reset, frame_req pulse, WRST_CYCLES=2 -> wrst_n low exactly 2 cycles, then s_ready=1; no we_n low during WRST.
REQ-036 FRAME_BYTES=4, continuous s_valid with data 0x10..0x13 -> we_n low 4 consecutive cycles carrying 0x10..0x13 one cycle after acceptance; frame_done single pulse; frame_cnt=1.
REQ-037 s_valid toggling 1,0,1,0 in WRITE -> we_n pattern 0,1,0,1 offset by one cycle; data order preserved.
REQ-038 in_rst asserted after 2 of 4 bytes -> all outputs at reset values next cycle; following frame_req repeats full WRST; no frame_done for the aborted frame.
REQ-039 256 frames of FRAME_BYTES=2 -> frame_cnt wraps to 0; frame_req held high -> exactly 1 IDLE cycle between frames.
REQ-040 With AL422_WR_FRAME_CHECK_EN, s_last on byte 2 of 4 -> err=1, no frame_done, return to IDLE; without the macro, same stimulus -> err=0 and a normal 4-byte frame.

Source files
------------

// File: rtl/al422_write_ctrl.sv
// AL422B FIFO write-side controller: pulses the write-pointer reset, then streams one frame of bytes.
// Define AL422_WR_FRAME_CHECK_EN to check frame length against s_last (sticky err flag).
module al422_write_ctrl #(
    parameter int FRAME_BYTES = 1024,
    parameter int WRST_CYCLES = 2
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       frame_req,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] al422_data,
    output logic       al422_we_n,
    output logic       al422_wrst_n,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, WRST, WRITE, DONE} state_t;

    localparam logic [15:0] LAST_IDX  = 16'(FRAME_BYTES - 1);
    localparam logic [3:0]  WRST_LAST = 4'(WRST_CYCLES - 1);
`ifdef AL422_WR_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [3:0]  wrst_cnt_q, wrst_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        we_n_q, we_n_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        short_q, short_d;
    logic        err_q, err_d;
    logic        accept, final_byte, early_last, missing_last;

    assign accept       = (state_q == WRITE) && s_valid;
    assign final_byte   = (byte_cnt_q == LAST_IDX);
    assign early_last   = CHECK_EN && accept && s_last && !final_byte;
    assign missing_last = CHECK_EN && accept && !s_last && final_byte;

    always_comb begin
        state_d     = state_q;
        wrst_cnt_d  = wrst_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        we_n_d      = !accept;
        frame_cnt_d = frame_cnt_q;
        short_d     = short_q;
        err_d       = err_q | early_last | missing_last;
        if (accept)
            data_d = s_data;
        unique case (state_q)
            IDLE: begin
                wrst_cnt_d = '0;
                short_d    = 1'b0;
                if (frame_req)
                    state_d = WRST;
            end
            WRST: begin
                byte_cnt_d = '0;
                if (wrst_cnt_q == WRST_LAST)
                    state_d = WRITE;
                else
                    wrst_cnt_d = wrst_cnt_q + 4'd1;
            end
            WRITE: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    // A truncated frame still passes through DONE so its last byte gets written.
                    if (final_byte || early_last) begin
                        state_d = DONE;
                        short_d = early_last;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!short_q)
                    frame_cnt_d = frame_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= IDLE;
            wrst_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            data_q      <= '0;
            we_n_q      <= 1'b1;
            frame_cnt_q <= '0;
            short_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrst_cnt_q  <= wrst_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            data_q      <= data_d;
            we_n_q      <= we_n_d;
            frame_cnt_q <= frame_cnt_d;
            short_q     <= short_d;
            err_q       <= err_d;
        end
    end

    assign s_ready      = (state_q == WRITE);
    assign busy         = (state_q != IDLE);
    assign al422_wrst_n = (state_q != WRST);
    assign al422_we_n   = we_n_q;
    assign al422_data   = data_q;
    assign frame_done   = (state_q == DONE) && !short_q;
    assign frame_cnt    = frame_cnt_q;
    assign err          = err_q & CHECK_EN;

endmodule
